mcycle_ctrl: RTL and testbench
==============================

# mcycle_ctrl

Multi-cycle CPU control sequencer. Steps the shared datapath (PC, IR, A/B, ALUOut, MDR registers, all 32-bit enable-gated flops) through fetch/decode/execute/memory/writeback, one state per cycle. Drives every register enable, mux select and memory strobe, and stalls on a memory-ready handshake. Sits beside the datapath; IR opcode and ALU Zero feed back into it.

## Interface
Parameters:
- none (encodings are fixed in the shared package)

Ports:
- Clk  in  1  clock; all state changes on rising edge
- Clr  in  1  asynchronous, active-high reset
- Op  in  6  opcode, IR[31:26]
- Zero  in  1  ALU zero flag
- MemRdy  in  1  memory completes the current read or write this cycle
- PcEn, IrEn, AbEn, AluOutEn, MdrEn  out  1 each  register enables
- RegWrite, MemRead, MemWrite  out  1 each  strobes
- IorD, AluSrcA, RegDst, MemToReg  out  1 each  mux selects
- AluSrcB  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- AluOp  out  2  00=add, 01=sub, 10=funct-decoded
- PcSrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
- State  out  4  current state code, for debug
- Illegal  out  1  sticky; unknown opcode decoded

## Operation
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000.
- Unlisted outputs are 0 in each state.
- FETCH(0): MemRead=1, IorD=0, AluSrcA=0, AluSrcB=01, AluOp=00, PcSrc=00. IrEn=PcEn=MemRdy. Stays until MemRdy, then DECODE.
- DECODE(1): AbEn=1, AluOutEn=1, AluSrcA=0, AluSrcB=11, AluOp=00. Next: R→EXE, lw/sw→MEMADR, beq→BRANCH, j→JUMP, addi→ADDIEX, other→HALT.
- MEMADR(2): AluSrcA=1, AluSrcB=10, AluOp=00, AluOutEn=1. lw→MEMRD, sw→MEMWR.
- MEMRD(3): MemRead=1, IorD=1, MdrEn=MemRdy. Hold until MemRdy, then MEMWB.
- MEMWB(4): RegWrite=1, RegDst=0, MemToReg=1. Next FETCH.
- MEMWR(5): MemWrite=1, IorD=1. Hold until MemRdy, then FETCH.
- EXE(6): AluSrcA=1, AluSrcB=00, AluOp=10, AluOutEn=1. Next RWB.
- RWB(7): RegWrite=1, RegDst=1, MemToReg=0. Next FETCH.
- BRANCH(8): AluSrcA=1, AluSrcB=00, AluOp=01, PcSrc=01, PcEn=Zero. Next FETCH.
- JUMP(9): PcSrc=10, PcEn=1. Next FETCH.
- ADDIEX(10): as MEMADR. Next ADDIWB.
- ADDIWB(11): RegWrite=1, RegDst=0, MemToReg=0. Next FETCH.
- HALT(12): all outputs 0 except Illegal=1. Leaves only on Clr.
- Codes 13–15 are unreachable; if entered, go to HALT.
- Op is sampled only in DECODE and MEMADR. It is held stable by IR, since IrEn is 0 outside FETCH.

## Timing
- Reset: State=FETCH(0) and Illegal=0, both asynchronous. While Clr=1, all enables and strobes are forced to 0. The first fetch strobe appears in the first cycle after Clr falls.
- Enables and strobes are combinational from State, plus MemRdy/Zero where listed. The datapath captures on the same edge.
- Latency with MemRdy=1 throughout: R=4, lw=5, sw=4, beq=3, j=3, addi=4 cycles.
- Each cycle of MemRdy=0 in FETCH, MEMRD or MEMWR adds one cycle. During a stall, strobes and selects stay asserted and the gated enables stay 0.
- Clr asserted mid-instruction: immediate return to FETCH. Partial writes already committed are not undone.
- MemRdy outside FETCH, MEMRD and MEMWR is ignored.

## Structure
- Shared package mcycle_pkg holds: state codes, opcode constants, AluSrcB/AluOp/PcSrc encodings.
- Sub-module mcycle_outdec: purely combinational state→control decode (State, MemRdy, Zero, Clr in; controls out).
- The top level keeps the state register, next-state logic and the Illegal flag.

## Test plan
- Reset then R-type (Op=000000), MemRdy=1: State sequence 0,1,6,7,0. RegWrite=1 and RegDst=1 only in cycle 4. PcEn pulses once, in cycle 1.
- lw with MemRdy low 2 cycles in MEMRD: sequence 0,1,2,3,3,3,4,0. MdrEn is 1 only in the third MEMRD cycle. MemToReg=1 in MEMWB.
- beq: with Zero=1, PcEn=1 and PcSrc=01 in BRANCH. Repeated with Zero=0, PcEn=0. Both return to FETCH after 3 cycles.
- FETCH stall: MemRdy=0 for 3 cycles gives MemRead=1, IrEn=0, PcEn=0 throughout. On MemRdy=1, IrEn=PcEn=1 for exactly one cycle.
- Op=111111: after DECODE, State=12 and Illegal=1 held for 10 cycles. Clr pulse gives State=0, Illegal=0.
- Clr asserted in MEMWR of sw: outputs drop to 0 immediately. After release, State=0 and MemRead=1.

Source files
------------

// File: rtl/mcycle_pkg.sv
// Shared encodings for the multi-cycle control sequencer:
// state codes, opcodes, mux encodings and the control bundle.
package mcycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXE    = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic       ir_en;
    logic       ab_en;
    logic       alu_out_en;
    logic       mdr_en;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       alu_src_a;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  function automatic state_t decode_next(
    input logic [5:0] op
  );
    state_t n;
    unique case (1'b1)
      op == OP_R:    n = S_EXE;
      op == OP_LW:   n = S_MEMADR;
      op == OP_SW:   n = S_MEMADR;
      op == OP_BEQ:  n = S_BRANCH;
      op == OP_J:    n = S_JUMP;
      op == OP_ADDI: n = S_ADDIEX;
      default:       n = S_HALT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mcycle_ctrl_outdec.sv
// Combinational state -> control decode; everything is
// forced low while clr is held.
module mcycle_ctrl_outdec
  import mcycle_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_rdy,
  input  logic       zero,
  input  logic       clr,
  output ctrl_t      ctrl
);

  ctrl_t c;

  always_comb begin
    c = '0;
    case (state)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_4;
        c.alu_op    = ALU_ADD;
        c.pc_src    = PC_ALU;
        c.ir_en     = mem_rdy;
        c.pc_en     = mem_rdy;
      end
      S_DECODE: begin
        c.ab_en      = 1'b1;
        c.alu_out_en = 1'b1;
        c.alu_src_b  = SRCB_IMM2;
        c.alu_op     = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_IMM;
        c.alu_op     = ALU_ADD;
        c.alu_out_en = 1'b1;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
        c.mdr_en   = mem_rdy;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXE: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_B;
        c.alu_op     = ALU_FUNCT;
        c.alu_out_en = 1'b1;
      end
      S_RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALU_SUB;
        c.pc_src    = PC_ALUOUT;
        c.pc_en     = zero;
      end
      S_JUMP: begin
        c.pc_src = PC_JUMP;
        c.pc_en  = 1'b1;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
      end
      default: c = '0;
    endcase
  end

  assign ctrl = clr ? '0 : c;

endmodule

// File: rtl/mcycle_ctrl.sv
// Multi-cycle sequencer: state register, next-state logic
// and the sticky illegal-opcode flag.
module mcycle_ctrl
  import mcycle_pkg::*;
(
  input  logic       Clk,
  input  logic       Clr,
  input  logic [5:0] Op,
  input  logic       Zero,
  input  logic       MemRdy,
  output logic       PcEn,
  output logic       IrEn,
  output logic       AbEn,
  output logic       AluOutEn,
  output logic       MdrEn,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       AluSrcA,
  output logic       RegDst,
  output logic       MemToReg,
  output logic [1:0] AluSrcB,
  output logic [1:0] AluOp,
  output logic [1:0] PcSrc,
  output logic [3:0] State,
  output logic       Illegal
);

  state_t state;
  state_t next;
  logic   illegal;
  ctrl_t  ctrl;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      state <= next;
      if (next == S_HALT)
        illegal <= 1'b1;
    end
  end

  always_comb begin
    next = state;
    case (state)
      S_FETCH:  if (MemRdy) next = S_DECODE;
      S_DECODE: next = decode_next(Op);
      S_MEMADR: begin
        unique case (1'b1)
          Op == OP_LW: next = S_MEMRD;
          Op == OP_SW: next = S_MEMWR;
          default:     next = S_HALT;
        endcase
      end
      S_MEMRD:  if (MemRdy) next = S_MEMWB;
      S_MEMWB:  next = S_FETCH;
      S_MEMWR:  if (MemRdy) next = S_FETCH;
      S_EXE:    next = S_RWB;
      S_RWB:    next = S_FETCH;
      S_BRANCH: next = S_FETCH;
      S_JUMP:   next = S_FETCH;
      S_ADDIEX: next = S_ADDIWB;
      S_ADDIWB: next = S_FETCH;
      S_HALT:   next = S_HALT;
      // codes 13-15 are unreachable; park them in HALT
      default:  next = S_HALT;
    endcase
  end

  mcycle_ctrl_outdec u_outdec (
    .state   (state),
    .mem_rdy (MemRdy),
    .zero    (Zero),
    .clr     (Clr),
    .ctrl    (ctrl)
  );

  assign PcEn     = ctrl.pc_en;
  assign IrEn     = ctrl.ir_en;
  assign AbEn     = ctrl.ab_en;
  assign AluOutEn = ctrl.alu_out_en;
  assign MdrEn    = ctrl.mdr_en;
  assign RegWrite = ctrl.reg_write;
  assign MemRead  = ctrl.mem_read;
  assign MemWrite = ctrl.mem_write;
  assign IorD     = ctrl.iord;
  assign AluSrcA  = ctrl.alu_src_a;
  assign RegDst   = ctrl.reg_dst;
  assign MemToReg = ctrl.mem_to_reg;
  assign AluSrcB  = ctrl.alu_src_b;
  assign AluOp    = ctrl.alu_op;
  assign PcSrc    = ctrl.pc_src;
  assign State    = state;
  assign Illegal  = illegal;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Scoreboard bench: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares.
module tb_mcycle_ctrl;

  localparam logic [5:0] O_R    = 6'b000000;
  localparam logic [5:0] O_LW   = 6'b100011;
  localparam logic [5:0] O_SW   = 6'b101011;
  localparam logic [5:0] O_BEQ  = 6'b000100;
  localparam logic [5:0] O_J    = 6'b000010;
  localparam logic [5:0] O_ADDI = 6'b001000;

  typedef struct packed {
    logic       pc_en;
    logic       ir_en;
    logic       ab_en;
    logic       alu_out_en;
    logic       mdr_en;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       alu_src_a;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal;
  } tctl_t;

  typedef struct packed {
    logic [3:0] st;
    tctl_t      c;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Clr;
  logic [5:0] Op;
  logic       Zero;
  logic       MemRdy;
  logic       PcEn, IrEn, AbEn, AluOutEn, MdrEn;
  logic       RegWrite, MemRead, MemWrite;
  logic       IorD, AluSrcA, RegDst, MemToReg;
  logic [1:0] AluSrcB, AluOp, PcSrc;
  logic [3:0] State;
  logic       Illegal;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t q[$];
  bit   clr_g = 1'b1;
  bit   ill_g = 1'b0;
  logic [5:0] op_g = 6'b0;

  mcycle_ctrl dut (
    .Clk(Clk), .Clr(Clr), .Op(Op), .Zero(Zero),
    .MemRdy(MemRdy),
    .PcEn(PcEn), .IrEn(IrEn), .AbEn(AbEn),
    .AluOutEn(AluOutEn), .MdrEn(MdrEn),
    .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .IorD(IorD),
    .AluSrcA(AluSrcA), .RegDst(RegDst),
    .MemToReg(MemToReg), .AluSrcB(AluSrcB),
    .AluOp(AluOp), .PcSrc(PcSrc),
    .State(State), .Illegal(Illegal)
  );

  always #5 Clk = ~Clk;

  // Control table written straight from the state descriptions.
  function automatic tctl_t ctrl_of(
    input int st, input bit r, input bit z,
    input bit clr, input bit ill
  );
    tctl_t c = '0;
    if (clr) return c;
    c.illegal = ill;
    case (st)
      0: begin
        c.mem_read = 1; c.alu_src_b = 2'b01;
        c.ir_en = r; c.pc_en = r;
      end
      1: begin
        c.ab_en = 1; c.alu_out_en = 1;
        c.alu_src_b = 2'b11;
      end
      2, 10: begin
        c.alu_src_a = 1; c.alu_src_b = 2'b10;
        c.alu_out_en = 1;
      end
      3: begin
        c.mem_read = 1; c.iord = 1; c.mdr_en = r;
      end
      4: begin c.reg_write = 1; c.mem_to_reg = 1; end
      5: begin c.mem_write = 1; c.iord = 1; end
      6: begin
        c.alu_src_a = 1; c.alu_op = 2'b10;
        c.alu_out_en = 1;
      end
      7: begin c.reg_write = 1; c.reg_dst = 1; end
      8: begin
        c.alu_src_a = 1; c.alu_op = 2'b01;
        c.pc_src = 2'b01; c.pc_en = z;
      end
      9: begin c.pc_src = 2'b10; c.pc_en = 1; end
      11: c.reg_write = 1;
      default: ;
    endcase
    return c;
  endfunction

  // One clock of stimulus; st is the state the model expects.
  task automatic do_cycle(
    input int st, input int rsel, input int zsel,
    output bit r
  );
    bit z;
    exp_t e;
    @(posedge Clk);
    #1;
    r = (rsel < 0) ? ($urandom_range(0, 2) != 0)
                   : (rsel != 0);
    z = (zsel < 0) ? $urandom_range(0, 1) != 0
                   : (zsel != 0);
    Clr    = clr_g;
    Op     = op_g;
    MemRdy = r;
    Zero   = z;
    if (clr_g) ill_g = 1'b0;
    e.st = clr_g ? 4'd0 : 4'(st);
    e.c  = ctrl_of(st, r, z, clr_g, ill_g);
    q.push_back(e);
  endtask

  task automatic run_instr(
    input logic [5:0] op, input int rsel, input int zsel
  );
    bit r;
    op_g = op;
    do do_cycle(0, rsel, zsel, r); while (!r);
    do_cycle(1, rsel, zsel, r);
    case (op)
      O_R: begin
        do_cycle(6, rsel, zsel, r);
        do_cycle(7, rsel, zsel, r);
      end
      O_LW: begin
        do_cycle(2, rsel, zsel, r);
        do do_cycle(3, rsel, zsel, r); while (!r);
        do_cycle(4, rsel, zsel, r);
      end
      O_SW: begin
        do_cycle(2, rsel, zsel, r);
        do do_cycle(5, rsel, zsel, r); while (!r);
      end
      O_BEQ:  do_cycle(8, rsel, zsel, r);
      O_J:    do_cycle(9, rsel, zsel, r);
      O_ADDI: begin
        do_cycle(10, rsel, zsel, r);
        do_cycle(11, rsel, zsel, r);
      end
      default: begin
        ill_g = 1'b1;
        repeat (10) do_cycle(12, rsel, zsel, r);
      end
    endcase
  endtask

  task automatic clr_pulse(input int n);
    bit r;
    clr_g = 1'b1;
    repeat (n) do_cycle(0, -1, -1, r);
    clr_g = 1'b0;
  endtask

  initial begin : monitor
    exp_t  e;
    tctl_t a;
    forever begin
      @(negedge Clk);
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {PcEn, IrEn, AbEn, AluOutEn, MdrEn,
             RegWrite, MemRead, MemWrite, IorD,
             AluSrcA, RegDst, MemToReg, AluSrcB,
             AluOp, PcSrc, Illegal};
        checks++;
        if (State !== e.st) begin
          failures++;
          $display("FAIL state cyc=%0d got=%0d exp=%0d",
                   cyc, State, e.st);
        end
        checks++;
        if (a !== e.c) begin
          failures++;
          $display("FAIL ctrl cyc=%0d st=%0d got=%h exp=%h",
                   cyc, e.st, a, e.c);
        end
      end
    end
  end

  initial begin : stim
    bit r;
    logic [5:0] ops [6];
    ops = '{O_R, O_LW, O_SW, O_BEQ, O_J, O_ADDI};
    Clr = 1'b1; Op = '0; Zero = 1'b0; MemRdy = 1'b0;
    clr_pulse(3);

    run_instr(O_R, 1, 0);

    op_g = O_LW;
    do_cycle(0, 1, 0, r);
    do_cycle(1, 1, 0, r);
    do_cycle(2, 1, 0, r);
    do_cycle(3, 0, 0, r);
    do_cycle(3, 0, 0, r);
    do_cycle(3, 1, 0, r);
    do_cycle(4, 1, 0, r);

    run_instr(O_BEQ, 1, 1);
    run_instr(O_BEQ, 1, 0);

    op_g = O_R;
    repeat (3) do_cycle(0, 0, 0, r);
    do_cycle(0, 1, 0, r);
    do_cycle(1, 1, 0, r);
    do_cycle(6, 1, 0, r);
    do_cycle(7, 1, 0, r);

    run_instr(O_J, 1, 0);
    run_instr(O_ADDI, 1, 0);
    run_instr(O_SW, 1, 0);

    // sw interrupted by Clr while stalled in MEMWR
    op_g = O_SW;
    do_cycle(0, 1, 0, r);
    do_cycle(1, 1, 0, r);
    do_cycle(2, 1, 0, r);
    do_cycle(5, 0, 0, r);
    clr_pulse(1);
    do_cycle(0, 0, 0, r);

    for (int i = 0; i < 300; i++)
      run_instr(ops[$urandom_range(0, 5)], -1, -1);

    run_instr(6'b111111, -1, -1);
    clr_pulse(1);
    run_instr(O_R, -1, -1);

    @(negedge Clk);
    @(negedge Clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
